sa_sequencer: RTL and testbench

//  Control sequencer for systolic_array_top. One host start request runs a full matmul pass:
//  - drives i_ctrl_state through IDLE->WARMUP->STEADY->DRAIN->DONE;
//  - drives the top/left/down SRAM read-window addresses from a configuration latched at start;
//  - gates host SRAM writes so operand buffers cannot be written while the array is running.

---
 rtl/sa_sequencer_if.sv | 46 ++++
 rtl/sa_sequencer.sv | 136 +++++++++++++
 tb/tb_sa_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sa_sequencer_if.sv
// Signal bundle between the host/array and sa_sequencer: pass control, read windows,
// host write gating and status. The sequencer takes the slave side.
`timescale 1ns/1ps
interface sa_sequencer_if #(
    parameter int AW = 5,
    parameter int CW = 4
);
    logic          i_start;
    logic          i_abort;
    logic [AW-1:0] i_top_start,  i_top_end;
    logic [AW-1:0] i_left_start, i_left_end;
    logic [AW-1:0] i_down_start, i_down_end;
    logic          i_host_top_wr_en;
    logic          i_host_left_wr_en;

    logic          o_top_wr_en;
    logic          o_left_wr_en;
    logic          o_wr_reject;
    logic [CW-1:0] o_ctrl_state;
    logic [AW-1:0] o_top_rd_start,  o_top_rd_end;
    logic [AW-1:0] o_left_rd_start, o_left_rd_end;
    logic [AW-1:0] o_down_rd_start, o_down_rd_end;
    logic          o_busy;
    logic          o_done;
    logic          o_cfg_err;

    modport slave (
        input  i_start, i_abort,
        input  i_top_start, i_top_end, i_left_start, i_left_end, i_down_start, i_down_end,
        input  i_host_top_wr_en, i_host_left_wr_en,
        output o_top_wr_en, o_left_wr_en, o_wr_reject, o_ctrl_state,
        output o_top_rd_start, o_top_rd_end, o_left_rd_start, o_left_rd_end,
        output o_down_rd_start, o_down_rd_end,
        output o_busy, o_done, o_cfg_err
    );

    modport master (
        output i_start, i_abort,
        output i_top_start, i_top_end, i_left_start, i_left_end, i_down_start, i_down_end,
        output i_host_top_wr_en, i_host_left_wr_en,
        input  o_top_wr_en, o_left_wr_en, o_wr_reject, o_ctrl_state,
        input  o_top_rd_start, o_top_rd_end, o_left_rd_start, o_left_rd_end,
        input  o_down_rd_start, o_down_rd_end,
        input  o_busy, o_done, o_cfg_err
    );
endinterface

// File: rtl/sa_sequencer.sv
// Control sequencer for the systolic array: runs IDLE->WARMUP->STEADY->DRAIN->DONE per start,
// latches the SRAM read windows at start and blocks host operand writes while a pass runs.
`timescale 1ns/1ps
module sa_sequencer #(
    parameter int NUM_ROW              = 4,
    parameter int NUM_COL              = 4,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int CTRL_WIDTH           = 4
) (
    input  logic          clk,
    input  logic          rst,
    sa_sequencer_if.slave bus
);
    localparam int AW        = LOG2_SRAM_BANK_DEPTH;
    localparam int DRAIN_LEN = NUM_ROW + NUM_COL - 1;
    localparam int CNT_W     = (AW + 1 > $clog2(DRAIN_LEN + 1)) ? AW + 1 : $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        STEADY = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]  top_start_q,  top_end_q;
    logic [AW-1:0]  left_start_q, left_end_q;
    logic [AW-1:0]  down_start_q, down_end_q;
    logic           cfg_err_q;
    logic           wr_reject_q;

    logic           win_bad;
    logic           host_wr_any;
    logic           in_idle;
    logic [AW-1:0]  steady_last;

    assign win_bad = (bus.i_top_end  < bus.i_top_start)  ||
                     (bus.i_left_end < bus.i_left_start) ||
                     (bus.i_down_end < bus.i_down_start);
    assign host_wr_any = bus.i_host_top_wr_en | bus.i_host_left_wr_en;
    assign in_idle     = (state_q == IDLE);
    // K-1 never wraps because a latched window always has end >= start.
    assign steady_last = left_end_q - left_start_q;

    // NOTE: every register below uses <= so all state updates see the pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            top_start_q  <= '0;
            top_end_q    <= '0;
            left_start_q <= '0;
            left_end_q   <= '0;
            down_start_q <= '0;
            down_end_q   <= '0;
            cfg_err_q    <= 1'b0;
            wr_reject_q  <= 1'b0;
        end else begin
            cfg_err_q   <= 1'b0;
            wr_reject_q <= host_wr_any && !in_idle;
            if (!in_idle && bus.i_abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.i_start) begin
                            if (win_bad) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                top_start_q  <= bus.i_top_start;
                                top_end_q    <= bus.i_top_end;
                                left_start_q <= bus.i_left_start;
                                left_end_q   <= bus.i_left_end;
                                down_start_q <= bus.i_down_start;
                                down_end_q   <= bus.i_down_end;
                                state_q      <= WARMUP;
                                cnt_q        <= CNT_W'(NUM_ROW - 1);
                            end
                        end
                    end
                    WARMUP: begin
                        if (cnt_q == '0) begin
                            state_q <= STEADY;
                            cnt_q   <= CNT_W'(steady_last);
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    STEADY: begin
                        if (cnt_q == '0) begin
                            state_q <= DRAIN;
                            cnt_q   <= CNT_W'(DRAIN_LEN - 1);
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (cnt_q == '0) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Write gating also drops while rst is high so every output reads 0 during reset.
    assign bus.o_top_wr_en  = bus.i_host_top_wr_en  & in_idle & ~rst;
    assign bus.o_left_wr_en = bus.i_host_left_wr_en & in_idle & ~rst;
    assign bus.o_wr_reject  = wr_reject_q;
    assign bus.o_cfg_err    = cfg_err_q;
    assign bus.o_ctrl_state = CTRL_WIDTH'(state_q);
    assign bus.o_busy       = !in_idle;
    assign bus.o_done       = (state_q == DONE);

    assign bus.o_top_rd_start  = top_start_q;
    assign bus.o_top_rd_end    = top_end_q;
    assign bus.o_left_rd_start = left_start_q;
    assign bus.o_left_rd_end   = left_end_q;
    assign bus.o_down_rd_start = down_start_q;
    assign bus.o_down_rd_end   = down_end_q;
endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer: per-cycle expected status is queued as stimulus
// is driven and popped/compared at every falling edge.
`timescale 1ns/1ps
module tb_sa_sequencer;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int WARM  = NR;
    localparam int DRAIN = NR + NC - 1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WARMUP = 4'd1;
    localparam logic [3:0] S_STEADY = 4'd2;
    localparam logic [3:0] S_DRAIN  = 4'd3;
    localparam logic [3:0] S_DONE   = 4'd4;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic       cfg;
        logic       rej;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    sa_sequencer_if #(.AW(AW), .CW(CW)) bus ();

    sa_sequencer #(
        .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW), .CTRL_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] status_now();
        return {bus.o_ctrl_state, bus.o_busy, bus.o_done, bus.o_cfg_err, bus.o_wr_reject};
    endfunction

    function automatic logic [29:0] windows_now();
        return {bus.o_top_rd_start, bus.o_top_rd_end, bus.o_left_rd_start,
                bus.o_left_rd_end, bus.o_down_rd_start, bus.o_down_rd_end};
    endfunction

    function automatic logic [29:0] win(input int ts, te, ls, le, ds, de);
        return {AW'(ts), AW'(te), AW'(ls), AW'(le), AW'(ds), AW'(de)};
    endfunction

    task automatic set_windows(input int ts, te, ls, le, ds, de);
        bus.i_top_start  = AW'(ts);  bus.i_top_end  = AW'(te);
        bus.i_left_start = AW'(ls);  bus.i_left_end = AW'(le);
        bus.i_down_start = AW'(ds);  bus.i_down_end = AW'(de);
    endtask

    task automatic push(input string tag, input logic [3:0] st, input logic cfg, input logic rej);
        exp_t e;
        e.tag = tag; e.st = st; e.cfg = cfg; e.rej = rej;
        exp_q.push_back(e);
    endtask

    // One clock: advance to the next falling edge and compare against the oldest expectation.
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, 64'(status_now()),
                  64'({e.st, e.st != S_IDLE, e.st == S_DONE, e.cfg, e.rej}));
        end
    endtask

    function automatic logic [3:0] pass_state(input int c, input int k, input int abort_at);
        if (abort_at != 0 && c > abort_at) return S_IDLE;
        if (c <= WARM)             return S_WARMUP;
        if (c <= WARM + k)         return S_STEADY;
        if (c <= WARM + k + DRAIN) return S_DRAIN;
        if (c == WARM + k + DRAIN + 1) return S_DONE;
        return S_IDLE;
    endfunction

    // Full pass from IDLE; cycle c is the c-th cycle after the edge that samples i_start.
    task automatic run_pass(input string tag, input int k, input int abort_at,
                            input int wr_at, input bit hold_start);
        int last;
        last = WARM + k + DRAIN + 1;
        bus.i_start = 1'b1;
        for (int c = 1; c <= last + 1; c++) begin
            push(tag, pass_state(c, k, abort_at), 1'b0, (wr_at != 0) && (c == wr_at + 1));
            step();
            if (!hold_start) bus.i_start = 1'b0;
            bus.i_abort = (c == abort_at);
            if (c == wr_at) begin
                bus.i_host_top_wr_en = 1'b1;
                #1 check({tag, "_wr_gated"}, 64'(bus.o_top_wr_en), 64'd0);
            end else begin
                bus.i_host_top_wr_en = 1'b0;
            end
        end
    endtask

    task automatic cfg_reject(input string tag, input logic [29:0] held);
        bus.i_start = 1'b1;
        push(tag, S_IDLE, 1'b1, 1'b0);
        step();
        bus.i_start = 1'b0;
        push({tag, "_after"}, S_IDLE, 1'b0, 1'b0);
        step();
        check({tag, "_windows"}, 64'(windows_now()), 64'(held));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_host_top_wr_en  = 1'b0;
        bus.i_host_left_wr_en = 1'b0;
        set_windows(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_status",  64'(status_now()), 64'd0);
        check("reset_windows", 64'(windows_now()), 64'd0);
        rst = 1'b0;

        // Basic pass with all windows 0..3.
        set_windows(0, 3, 0, 3, 0, 3);
        run_pass("pass_basic", 4, 0, 0, 1'b0);
        check("basic_windows", 64'(windows_now()), 64'(win(0, 3, 0, 3, 0, 3)));

        // Bad windows are refused and leave the latched windows alone.
        set_windows(1, 1, 2, 1, 0, 0);
        cfg_reject("cfg_left", win(0, 3, 0, 3, 0, 3));
        set_windows(0, 0, 0, 0, 7, 6);
        cfg_reject("cfg_down", win(0, 3, 0, 3, 0, 3));
        set_windows(9, 8, 0, 0, 0, 0);
        cfg_reject("cfg_top", win(0, 3, 0, 3, 0, 3));

        // Boundary window lengths: K=1 and the full K=32 bank.
        set_windows(1, 2, 9, 9, 4, 20);
        run_pass("pass_k1", 1, 0, 0, 1'b0);
        check("k1_windows", 64'(windows_now()), 64'(win(1, 2, 9, 9, 4, 20)));
        set_windows(3, 31, 0, 31, 30, 31);
        run_pass("pass_k32", 32, 0, 0, 1'b0);

        // Abort in STEADY cycle 6; no DONE, windows stay latched.
        set_windows(2, 5, 4, 7, 6, 9);
        run_pass("pass_abort", 4, 6, 0, 1'b0);
        set_windows(11, 12, 13, 14, 15, 16);
        #1 check("abort_windows", 64'(windows_now()), 64'(win(2, 5, 4, 7, 6, 9)));

        // Host writes in IDLE pass; during DRAIN they are dropped and reported.
        bus.i_host_left_wr_en = 1'b1;
        #1 check("idle_left_wr", 64'(bus.o_left_wr_en), 64'd1);
        push("idle_left_wr_status", S_IDLE, 1'b0, 1'b0);
        step();
        bus.i_host_left_wr_en = 1'b0;
        set_windows(0, 3, 0, 3, 0, 3);
        bus.i_host_top_wr_en = 1'b1;
        #1 check("idle_top_wr_with_start", 64'(bus.o_top_wr_en), 64'd1);
        run_pass("pass_wr_drain", 4, 0, 10, 1'b0);

        // Start held high: exactly one IDLE cycle between back-to-back passes.
        set_windows(0, 3, 1, 2, 0, 3);
        run_pass("pass_hold1", 2, 0, 0, 1'b1);
        run_pass("pass_hold2", 2, 0, 0, 1'b0);
        push("hold_idle", S_IDLE, 1'b0, 1'b0);
        step();

        // Asynchronous reset in WARMUP clears every output before the next edge.
        set_windows(0, 3, 0, 3, 0, 3);
        bus.i_start = 1'b1;
        push("rst_warm1", S_WARMUP, 1'b0, 1'b0);
        step();
        bus.i_start = 1'b0;
        push("rst_warm2", S_WARMUP, 1'b0, 1'b0);
        step();
        bus.i_host_top_wr_en = 1'b1;
        #2 rst = 1'b1;
        #1 check("async_rst_status", 64'(status_now()), 64'd0);
        check("async_rst_windows", 64'(windows_now()), 64'd0);
        check("async_rst_wr_en", 64'({bus.o_top_wr_en, bus.o_left_wr_en}), 64'd0);
        bus.i_host_top_wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            push("post_rst_idle", S_IDLE, 1'b0, 1'b0);
            step();
        end
        run_pass("pass_post_rst", 4, 0, 0, 1'b0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
